// File: rtl/dlfloat16_pkg.sv
// DLFloat16 shared constants and field helpers.
// Used by the add/sub pre-normalize datapath.
package dlfloat16_pkg;

    localparam int EXP_W     = 6;
    localparam int MAN_W     = 9;
    localparam int BIAS      = 31;
    localparam int GRS_W     = 4;
    localparam int SIG_EXT_W = 14;

    localparam logic [18:0] SPECIAL_WORD20 = {6'h3F, 9'h1FF, 4'h0};
    localparam logic [19:0] ZERO_WORD20    = 20'h00000;

    function automatic logic f_sign(input logic [15:0] x);
        return x[15];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [15:0] x);
        return x[14:9];
    endfunction

    function automatic logic [MAN_W-1:0] f_frac(input logic [15:0] x);
        return x[8:0];
    endfunction

endpackage

// File: rtl/dlfloat16_lzc.sv
// Leading-zero count of the 15-bit sum.
// All-zero input reports 15.
module dlfloat16_lzc (
    input  logic [14:0] val_i,
    output logic [3:0]  lz_o
);

    // highest set bit wins since it is visited last
    always_comb begin
        lz_o = 4'd15;
        for (int i = 0; i < 15; i++) begin
            if (val_i[i]) lz_o = 4'(14 - i);
        end
    end

endmodule

// File: rtl/dlfloat16_addsub_prenorm.sv
// DLFloat16 add/sub: align, add, normalize (3 stages).
// Emits the unrounded {sign, exp, frac, G, R, S1, S2} word.
module dlfloat16_addsub_prenorm
    import dlfloat16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_word
);

    logic stall;

    logic [EXP_W-1:0] ea, eb, exp_l, exp_s, dexp;
    logic [13:0] sig_a, sig_b, sig_l, sig_s, sig_al;
    logic [13:0] shifted, mask;
    logic spa, spb;
    logic s1_sign_d, s1_sub_d, s1_spc_d, s1_spsign_d;

    logic             s1_v_q, s1_sign_q, s1_sub_q;
    logic             s1_spc_q, s1_spsign_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [13:0]      s1_sigl_q, s1_sigs_q;

    logic [14:0]      s2_sum_d;
    logic             s2_v_q, s2_sign_q, s2_spc_q, s2_spsign_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [14:0]      s2_sum_q;

    logic [3:0]         lz;
    logic [13:0]        norm;
    logic signed [7:0]  e_n;
    logic [19:0]        word_d;
    logic               out_valid_q;
    logic [19:0]        word_q;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_word  = word_q;

    // unpack, order by magnitude, align the smaller significand
    always_comb begin
        ea    = f_exp(a);
        eb    = f_exp(b);
        spa   = (ea == 6'h3F);
        spb   = (eb == 6'h3F);
        sig_a = (ea == 6'd0) ? 14'd0 : {1'b1, f_frac(a), 4'b0};
        sig_b = (eb == 6'd0) ? 14'd0 : {1'b1, f_frac(b), 4'b0};
        if (a[14:0] >= b[14:0]) begin
            exp_l     = ea;
            exp_s     = eb;
            sig_l     = sig_a;
            sig_s     = sig_b;
            s1_sign_d = f_sign(a);
        end else begin
            exp_l     = eb;
            exp_s     = ea;
            sig_l     = sig_b;
            sig_s     = sig_a;
            s1_sign_d = f_sign(b) ^ op;
        end
        dexp    = exp_l - exp_s;
        shifted = '0;
        mask    = '0;
        sig_al  = '0;
        if (dexp >= 6'd14) begin
            sig_al[0] = |sig_s;
        end else begin
            shifted   = sig_s >> dexp;
            mask      = ~(14'h3FFF << dexp);
            sig_al    = shifted;
            sig_al[0] = shifted[0] | (|(sig_s & mask));
        end
        s1_sub_d    = f_sign(a) ^ f_sign(b) ^ op;
        s1_spc_d    = spa | spb;
        s1_spsign_d = spa ? f_sign(a) : f_sign(b);
    end

    // stage 1 register: aligned operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_spc_q    <= 1'b0;
            s1_spsign_q <= 1'b0;
            s1_exp_q    <= '0;
            s1_sigl_q   <= '0;
            s1_sigs_q   <= '0;
        end else if (!stall) begin
            s1_v_q      <= in_valid;
            s1_sign_q   <= s1_sign_d;
            s1_sub_q    <= s1_sub_d;
            s1_spc_q    <= s1_spc_d;
            s1_spsign_q <= s1_spsign_d;
            s1_exp_q    <= exp_l;
            s1_sigl_q   <= sig_l;
            s1_sigs_q   <= sig_al;
        end
    end

    // magnitude add or subtract; larger operand first so never negative
    always_comb begin
        if (s1_sub_q) s2_sum_d = {1'b0, s1_sigl_q} - {1'b0, s1_sigs_q};
        else          s2_sum_d = {1'b0, s1_sigl_q} + {1'b0, s1_sigs_q};
    end

    // stage 2 register: raw sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q      <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_spc_q    <= 1'b0;
            s2_spsign_q <= 1'b0;
            s2_exp_q    <= '0;
            s2_sum_q    <= '0;
        end else if (!stall) begin
            s2_v_q      <= s1_v_q;
            s2_sign_q   <= s1_sign_q;
            s2_spc_q    <= s1_spc_q;
            s2_spsign_q <= s1_spsign_q;
            s2_exp_q    <= s1_exp_q;
            s2_sum_q    <= s2_sum_d;
        end
    end

    dlfloat16_lzc u_lzc (
        .val_i (s2_sum_q),
        .lz_o  (lz)
    );

    // normalize so the hidden bit sits at bit 13, then classify
    always_comb begin
        if (s2_sum_q[14]) begin
            norm    = s2_sum_q[14:1];
            norm[0] = s2_sum_q[1] | s2_sum_q[0];
            e_n     = $signed({2'b00, s2_exp_q}) + 8'sd1;
        end else begin
            norm = s2_sum_q[13:0] << (lz - 4'd1);
            e_n  = $signed({2'b00, s2_exp_q})
                 - $signed({4'b0000, lz}) + 8'sd1;
        end
        if (s2_spc_q)
            word_d = {s2_spsign_q, SPECIAL_WORD20};
        else if (s2_sum_q == 15'd0)
            word_d = ZERO_WORD20;
        else if (e_n <= 8'sd0)
            word_d = ZERO_WORD20;
        else if (e_n >= 8'sd63)
            word_d = {s2_sign_q, SPECIAL_WORD20};
        else
            word_d = {s2_sign_q, e_n[5:0], norm[12:0]};
    end

    // output register: held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            word_q      <= ZERO_WORD20;
        end else if (!stall) begin
            out_valid_q <= s2_v_q;
            word_q      <= word_d;
        end
    end

endmodule

// File: tb/tb_dlfloat16_addsub_prenorm.sv
// Bench for dlfloat16_addsub_prenorm: directed vectors,
// arithmetic reference model and scoreboard compare.
module tb_dlfloat16_addsub_prenorm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_word;

    int checks = 0;
    int errors = 0;

    logic [19:0] q[$];
    logic        prev_stall = 1'b0;
    logic [19:0] prev_word = '0;

    localparam int NV = 14;
    logic [15:0] va[NV] = '{16'h3E00, 16'h3E00, 16'h3F00, 16'h3E00,
                            16'h3E00, 16'h7FFF, 16'h7DFF, 16'h0000,
                            16'h3E00, 16'h0000, 16'h0300, 16'h3E00,
                            16'h3E00, 16'h3E00};
    logic [15:0] vb[NV] = '{16'h3E00, 16'h3E00, 16'h3E00, 16'h2A00,
                            16'h1600, 16'h3E00, 16'h7DFF, 16'h3E00,
                            16'h0000, 16'h3E00, 16'h0200, 16'hFE00,
                            16'h1600, 16'h3F00};
    logic        vo[NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [19:0] ve[NV] = '{20'h40000, 20'h00000, 20'h3C000, 20'h3E008,
                            20'h3E001, 20'h7FFF0, 20'h7FFF0, 20'h3E000,
                            20'h3E000, 20'hBE000, 20'h00000, 20'hFFFF0,
                            20'h3DFFE, 20'hBC000};

    always #5 clk = ~clk;

    dlfloat16_addsub_prenorm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word)
    );

    // Reference: significands as integers in units of 2^-13 of the
    // hidden bit, jammed alignment, then normalize by plain scaling.
    function automatic logic [19:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic o);
        int ex, ey, mx, my, el, es, ml, ms, d, s, r, e;
        bit sl, sub;
        ex = int'(x[14:9]);
        ey = int'(y[14:9]);
        if (ex == 63 || ey == 63)
            return {(ex == 63) ? x[15] : y[15], 19'h7FFF0};
        mx = (ex == 0) ? 0 : (512 + int'(x[8:0])) * 16;
        my = (ey == 0) ? 0 : (512 + int'(y[8:0])) * 16;
        if (x[14:0] >= y[14:0]) begin
            el = ex; ml = mx; sl = x[15]; es = ey; ms = my;
        end else begin
            el = ey; ml = my; sl = y[15] ^ o; es = ex; ms = mx;
        end
        sub = x[15] ^ y[15] ^ o;
        d = el - es;
        if (d >= 14) begin
            s = (ms != 0) ? 1 : 0;
        end else begin
            s = ms >> d;
            if ((ms % (1 << d)) != 0) s = s | 1;
        end
        r = sub ? ml - s : ml + s;
        if (r == 0) return 20'h00000;
        e = el;
        while (r >= 16384) begin
            r = (r / 2) | (r % 2);
            e++;
        end
        while (r < 8192) begin
            r = r * 2;
            e--;
        end
        if (e <= 0) return 20'h00000;
        if (e >= 63) return {sl, 19'h7FFF0};
        return {sl, 6'(e), 13'(r - 8192)};
    endfunction

    task automatic chk(input string nm, input logic [19:0] act,
                       input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // scoreboard: push accepted inputs, check every output transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 20'(out_valid), 20'd1);
                chk("hold_word", out_word, prev_word);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none",
                             out_word);
                end else begin
                    chk("scoreboard", out_word, q.pop_front());
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_word  = out_word;
            if (in_valid && in_ready) q.push_back(model(a, b, op));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] exp3[3];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 20'(out_valid), 20'd0);
        chk("rst_word", out_word, 20'h00000);
        chk("rst_ready", 20'(in_ready), 20'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // latency: 1.0 + 1.0 visible exactly 3 cycles after offer
        a = 16'h3E00; b = 16'h3E00; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("latency_c%0d", k), 20'(out_valid),
                20'(k == 3));
        end
        chk("latency_word", out_word, 20'h40000);
        repeat (3) @(posedge clk);
        #1;

        // pin the model against hand-computed words
        for (int i = 0; i < NV; i++)
            chk($sformatf("model_v%0d", i),
                model(va[i], vb[i], vo[i]), ve[i]);

        // stream all vectors back to back
        for (int i = 0; i < NV; i++) begin
            a = va[i]; b = vb[i]; op = vo[i]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // backpressure: three ops, out_ready low for 4 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = va[i + 2]; b = vb[i + 2]; op = vo[i + 2];
            exp3[i] = ve[i + 2];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        a = va[12]; b = vb[12]; op = vo[12];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 20'(in_ready), 20'd0);
            chk("bp_valid", 20'(out_valid), 20'd1);
            chk("bp_word", out_word, exp3[0]);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_order%0d_v", k), 20'(out_valid), 20'd1);
            chk($sformatf("bp_order%0d", k), out_word, exp3[k]);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;

        // reset with one result on the output and two in flight
        for (int i = 0; i < 3; i++) begin
            a = va[i * 3]; b = vb[i * 3]; op = vo[i * 3];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 20'(out_valid), 20'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 20'(out_valid), 20'd0);
        chk("mid_rst_word", out_word, 20'h00000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_stale", 20'(out_valid), 20'd0);
        end

        chk("drain", 20'(q.size()), 20'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlfloat16_addsub_prenorm.md
Name: dlfloat16_addsub_prenorm

Overview:
- Three-stage pipelined DLFloat16 add/subtract datapath: unpack/align, add, normalize.
- Produces the 20-bit unrounded word consumed directly by dlfloat16_round.
- Word layout is {sign, exp[5:0], frac[8:0], G, R, S1, S2}.
- Valid/ready on both sides; global stall on output backpressure.

Parameters:
- EXP_W, 6, exponent width. Only the default is supported.
- MAN_W, 9, stored fraction width, hidden bit excluded. Only the default is supported.
- BIAS, 31, exponent bias.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- a  in  16  DLFloat16 operand A, {sign, exp6, frac9}
- b  in  16  DLFloat16 operand B
- op  in  1  0 = A+B, 1 = A-B
- out_valid  out  1  out_word valid
- out_ready  in  1  downstream accepts out_word
- out_word  out  20  unrounded result {sign, exp6, frac9, G, R, S1, S2}

Behaviour:
- Reset:
  - All stage valid bits clear; out_valid = 0.
  - out_word = 20'h00000 and all pipeline data registers cleared.
  - in_ready = 1 after reset.
- Handshake and stall:
  - Input transfers on in_valid & in_ready. Output transfers on out_valid & out_ready.
  - stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stall is high, every stage register holds and no bubble collapse occurs.
- Latency: exactly 3 cycles from input transfer to out_valid when not stalled. Throughput is 1 per cycle. Order is preserved.
- Stage 1, unpack and align:
  - exp == 0 means zero, with the significand forced to 0.
  - exp == 63 means special.
  - Significand is {1, frac}, 10 bits, extended by 4 zero bits to 14 bits.
  - Effective sign of B is b.sign ^ op. Effective subtract is a.sign ^ b.sign ^ op.
  - Swap operands so the larger {exp, frac} magnitude is L.
  - d = expL - expS.
  - The smaller significand shifts right by d. Bits shifted out are ORed into bit 0 (S2).
  - If d >= 14, the aligned value is 0 and S2 = |significand.
- Stage 2, add:
  - 15-bit result = L + S, or L - S on effective subtract. The result is never negative.
  - Result sign = sign of L.
- Stage 3, normalize:
  - Carry (bit 14) set: shift right 1, OR the lost bit into S2, exp + 1.
  - Otherwise: left shift by the leading-zero count so the hidden bit sits at bit 13, zero-filled; exp - lz.
  - Output frac = bits [12:4]; G R S1 S2 = bits [3:0].
- Boundary cases:
  - Result magnitude 0 (equal-magnitude subtract, or both operands zero): out_word = 20'h00000, sign forced +.
  - One operand zero: result is the other operand with GRS = 0.
  - Post-normalize exp <= 0: flush to 20'h00000.
  - Post-normalize exp >= 63: {sign, 6'h3F, 9'h1FF, 4'h0}.
  - Either input special: {sign of the special operand (A if both), 6'h3F, 9'h1FF, 4'h0}.
- Reset mid-operation: all in-flight results are discarded. No out_valid is produced for them.

Decomposition:
- dlfloat16_pkg holds:
  - EXP_W, MAN_W, BIAS, GRS_W = 4
  - SIG_EXT_W = 14
  - SPECIAL_WORD20 = {6'h3F, 9'h1FF, 4'h0} sans sign
  - ZERO_WORD20
  - field-extract functions for sign, exp and frac
- Sub-module dlfloat16_lzc: combinational leading-zero count of the 15-bit sum, 4-bit result. Used in stage 3.

Test Plan:
- 1.0 + 1.0: a = 16'h3E00, b = 16'h3E00, op = 0 -> out_word 20'h40000 exactly 3 cycles later.
- 1.0 - 1.0: a = 16'h3E00, b = 16'h3E00, op = 1 -> 20'h00000. Also 1.5 - 1.0 (a = 16'h3F00, b = 16'h3E00, op = 1) -> 20'h3C000 (left normalize).
- 1.0 + 2^-10: a = 16'h3E00, b = 16'h2A00 -> 20'h3E008 (G = 1). 1.0 + 2^-20 (b = 16'h1600) -> 20'h3E001 (sticky only).
- Special: a = 16'h7FFF, b = 16'h3E00 -> 20'h7FFF0. Also max + max (a = b = 16'h7DFF) -> exponent overflow -> 20'h7FFF0.
- Backpressure:
  - Stimulus: three back-to-back ops; out_ready low from the first out_valid for 4 cycles.
  - Required: out_word held stable and in_ready low throughout; no input accepted; after release, the three results appear in order on consecutive cycles.
- Reset mid-flight: assert rst_n low with 2 ops in the pipe -> out_valid = 0 and out_word = 0 immediately; no stale result after release.
